// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline control pipes and the hazard controller.
// No valid/ready: every field is a level that both sides sample once per cycle.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       A1_D;
  logic [4:0]       A2_D;
  logic [1:0]       tuse_rs;
  logic [1:0]       tuse_rt;
  logic             md_use_D;
  logic [4:0]       A1_E;
  logic [4:0]       A2_E;
  logic [4:0]       A2_M;
  logic [1:0]       Res_E;
  logic [1:0]       Res_M;
  logic [1:0]       Res_W;
  logic [4:0]       A3_E;
  logic [4:0]       A3_M;
  logic [4:0]       A3_W;
  logic             md_start;
  logic             md_is_div;

  logic             stall;
  logic             flush_E;
  logic [2:0]       fwd_rs_D;
  logic [2:0]       fwd_rt_D;
  logic [1:0]       fwd_rs_E;
  logic [1:0]       fwd_rt_E;
  logic             fwd_rt_M;
  logic             fwd_M_pc;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output A1_D, A2_D, tuse_rs, tuse_rt, md_use_D, A1_E, A2_E, A2_M,
           Res_E, Res_M, Res_W, A3_E, A3_M, A3_W, md_start, md_is_div,
    input  stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
           fwd_rt_M, fwd_M_pc, md_busy, stall_cnt
  );

  modport slave (
    input  A1_D, A2_D, tuse_rs, tuse_rt, md_use_D, A1_E, A2_E, A2_M,
           Res_E, Res_M, Res_W, A3_E, A3_M, A3_W, md_start, md_is_div,
    output stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
           fwd_rt_M, fwd_M_pc, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush and forwarding-select generation for the 5-stage pipeline,
// plus the mult/div busy counter and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 32
) (
  input logic           clk,
  input logic           reset,
  hazard_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int BW      = $clog2(MAX_CYC + 1);
  localparam logic [BW-1:0] MULT_LD = BW'(MULT_CYC);
  localparam logic [BW-1:0] DIV_LD  = BW'(DIV_CYC);

  logic [BW-1:0]    md_cnt;
  logic [CNT_W-1:0] stall_cnt_q;

  logic       hit_rs_e, hit_rs_m, hit_rs_w;
  logic       hit_rt_e, hit_rt_m, hit_rt_w;
  logic       hit_e1_m, hit_e1_w, hit_e2_m, hit_e2_w, hit_m2_w;
  logic [1:0] tnew_e, tnew_m;
  logic       data_stall, md_stall, stall_c;

  // A stage only produces a value when it writes a non-zero register.
  function automatic logic hit(input logic [4:0] a3, input logic [1:0] res,
                               input logic [4:0] idx);
    return (a3 == idx) && (a3 != 5'd0) && (res != 2'd0);
  endfunction

  // Only the youngest matching stage decides; W always has Tnew = 0.
  function automatic logic op_stall(input logic [1:0] tuse, input logic he,
                                    input logic hm, input logic [1:0] tne,
                                    input logic [1:0] tnm);
    logic s;
    s = 1'b0;
    if (tuse != 2'd3) begin
      if (he)      s = (tne > tuse);
      else if (hm) s = (tnm > tuse);
    end
    return s;
  endfunction

  function automatic logic [2:0] d_sel(input logic he, input logic hm,
                                       input logic hw, input logic [1:0] res_e,
                                       input logic [1:0] res_m);
    logic [2:0] s;
    s = 3'd0;
    if (he) begin
      if (res_e == 2'd3) s = 3'd1;
    end else if (hm) begin
      if (res_m == 2'd1)      s = 3'd2;
      else if (res_m == 2'd3) s = 3'd3;
    end else if (hw) begin
      s = 3'd4;
    end
    return s;
  endfunction

  function automatic logic [1:0] e_sel(input logic hm, input logic hw,
                                       input logic [1:0] res_m);
    logic [1:0] s;
    s = 2'd0;
    if (hm && (res_m != 2'd2)) s = 2'd1;
    else if (hw)               s = 2'd2;
    return s;
  endfunction

  always_comb begin
    hit_rs_e = hit(bus.A3_E, bus.Res_E, bus.A1_D);
    hit_rs_m = hit(bus.A3_M, bus.Res_M, bus.A1_D);
    hit_rs_w = hit(bus.A3_W, bus.Res_W, bus.A1_D);
    hit_rt_e = hit(bus.A3_E, bus.Res_E, bus.A2_D);
    hit_rt_m = hit(bus.A3_M, bus.Res_M, bus.A2_D);
    hit_rt_w = hit(bus.A3_W, bus.Res_W, bus.A2_D);
    hit_e1_m = hit(bus.A3_M, bus.Res_M, bus.A1_E);
    hit_e1_w = hit(bus.A3_W, bus.Res_W, bus.A1_E);
    hit_e2_m = hit(bus.A3_M, bus.Res_M, bus.A2_E);
    hit_e2_w = hit(bus.A3_W, bus.Res_W, bus.A2_E);
    hit_m2_w = hit(bus.A3_W, bus.Res_W, bus.A2_M);

    case (bus.Res_E)
      2'd1:    tnew_e = 2'd1;
      2'd2:    tnew_e = 2'd2;
      default: tnew_e = 2'd0;
    endcase
    tnew_m = (bus.Res_M == 2'd2) ? 2'd1 : 2'd0;

    data_stall = op_stall(bus.tuse_rs, hit_rs_e, hit_rs_m, tnew_e, tnew_m) |
                 op_stall(bus.tuse_rt, hit_rt_e, hit_rt_m, tnew_e, tnew_m);
    md_stall   = bus.md_use_D && ((md_cnt != '0) || bus.md_start);
    stall_c    = data_stall | md_stall;
  end

  assign bus.stall     = stall_c;
  assign bus.flush_E   = stall_c;
  assign bus.fwd_rs_D  = d_sel(hit_rs_e, hit_rs_m, hit_rs_w, bus.Res_E, bus.Res_M);
  assign bus.fwd_rt_D  = d_sel(hit_rt_e, hit_rt_m, hit_rt_w, bus.Res_E, bus.Res_M);
  assign bus.fwd_rs_E  = e_sel(hit_e1_m, hit_e1_w, bus.Res_M);
  assign bus.fwd_rt_E  = e_sel(hit_e2_m, hit_e2_w, bus.Res_M);
  assign bus.fwd_rt_M  = hit_m2_w;
  assign bus.fwd_M_pc  = (bus.Res_M == 2'd3);
  assign bus.md_busy   = (md_cnt != '0);
  assign bus.stall_cnt = stall_cnt_q;

  // A fresh issue reloads the counter even while a previous op is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt      <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.md_start)        md_cnt <= bus.md_is_div ? DIV_LD : MULT_LD;
      else if (md_cnt != '0)   md_cnt <= md_cnt - 1'b1;
      if (stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a table-driven
// reference model of the stall/forwarding rules and both counters.
module tb_hazard_ctrl;

  localparam int TB_CNT_W = 6;
  localparam int SAT      = (1 << TB_CNT_W) - 1;
  localparam int W        = 15 + TB_CNT_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hif();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: remaining busy cycles and stalled-cycle total.
  int m_busy = 0;
  int m_scnt = 0;

  logic [W-1:0] exp_q[$];

  // Tnew indexed by [stage E/M/W][Res]; D-forward select for an M hit by Res.
  int tnew_tab[3][4] = '{'{0, 1, 2, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 0}};
  int dsel_m_tab[4]  = '{0, 2, 0, 3};

  function automatic int stage_res(int s);
    case (s)
      0:       return int'(hif.Res_E);
      1:       return int'(hif.Res_M);
      default: return int'(hif.Res_W);
    endcase
  endfunction

  function automatic int stage_a3(int s);
    case (s)
      0:       return int'(hif.A3_E);
      1:       return int'(hif.A3_M);
      default: return int'(hif.A3_W);
    endcase
  endfunction

  // Youngest stage at or after 'from' that writes register idx, else -1.
  function automatic int find_src(int idx, int from);
    int r;
    r = -1;
    for (int s = from; s < 3; s++)
      if (r < 0 && idx != 0 && stage_a3(s) == idx && stage_res(s) != 0) r = s;
    return r;
  endfunction

  function automatic int need_stall(int idx, int tuse);
    int s;
    s = find_src(idx, 0);
    if (tuse == 3 || s < 0) return 0;
    return (tnew_tab[s][stage_res(s)] > tuse) ? 1 : 0;
  endfunction

  function automatic int dsel(int idx);
    int s;
    s = find_src(idx, 0);
    if (s == 0) return (stage_res(0) == 3) ? 1 : 0;
    if (s == 1) return dsel_m_tab[stage_res(1)];
    if (s == 2) return 4;
    return 0;
  endfunction

  function automatic int esel(int idx);
    if (find_src(idx, 1) == 1 && stage_res(1) != 2) return 1;
    if (find_src(idx, 2) == 2) return 2;
    return 0;
  endfunction

  function automatic logic [W-1:0] model_out();
    int st;
    st = need_stall(int'(hif.A1_D), int'(hif.tuse_rs)) |
         need_stall(int'(hif.A2_D), int'(hif.tuse_rt));
    if (hif.md_use_D && (m_busy > 0 || hif.md_start)) st = 1;
    return {1'(st), 1'(st),
            3'(dsel(int'(hif.A1_D))), 3'(dsel(int'(hif.A2_D))),
            2'(esel(int'(hif.A1_E))), 2'(esel(int'(hif.A2_E))),
            1'(find_src(int'(hif.A2_M), 2) == 2), 1'(hif.Res_M == 2'd3),
            1'(m_busy > 0), TB_CNT_W'(m_scnt)};
  endfunction

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cycle(input string tag);
    logic [W-1:0] exp, obs;
    @(negedge clk);
    exp_q.push_back(model_out());
    obs = {hif.stall, hif.flush_E, hif.fwd_rs_D, hif.fwd_rt_D, hif.fwd_rs_E,
           hif.fwd_rt_E, hif.fwd_rt_M, hif.fwd_M_pc, hif.md_busy, hif.stall_cnt};
    exp = exp_q.pop_front();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h (stall,flush,rsD,rtD,rsE,rtE,rtM,mpc,busy,cnt)",
             tag, obs, exp);
    end
    @(posedge clk);
    if (reset) begin
      m_busy = 0;
      m_scnt = 0;
    end else begin
      if (exp[W-1] && m_scnt < SAT) m_scnt++;
      if (hif.md_start)   m_busy = hif.md_is_div ? 10 : 5;
      else if (m_busy > 0) m_busy--;
    end
    #1;
  endtask

  task automatic drive_d(input int a1, input int a2, input int tr, input int tt,
                         input int mdu);
    hif.A1_D = 5'(a1); hif.A2_D = 5'(a2);
    hif.tuse_rs = 2'(tr); hif.tuse_rt = 2'(tt); hif.md_use_D = 1'(mdu);
  endtask

  task automatic drive_pipe(input int re, input int ae, input int rm, input int am,
                            input int rw, input int aw);
    hif.Res_E = 2'(re); hif.A3_E = 5'(ae);
    hif.Res_M = 2'(rm); hif.A3_M = 5'(am);
    hif.Res_W = 2'(rw); hif.A3_W = 5'(aw);
  endtask

  task automatic drive_e(input int a1e, input int a2e, input int a2m);
    hif.A1_E = 5'(a1e); hif.A2_E = 5'(a2e); hif.A2_M = 5'(a2m);
  endtask

  task automatic drive_md(input int start, input int div);
    hif.md_start = 1'(start); hif.md_is_div = 1'(div);
  endtask

  task automatic idle();
    drive_d(0, 0, 3, 3, 0);
    drive_pipe(0, 0, 0, 0, 0, 0);
    drive_e(0, 0, 0);
    drive_md(0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    cycle("reset_state");
    reset = 1'b0;

    // lw in E feeding addu rs in D
    drive_pipe(2, 8, 0, 0, 0, 0); drive_d(8, 0, 1, 3, 0);
    cycle("lw_use_stall");
    drive_pipe(0, 0, 2, 8, 0, 0);
    cycle("lw_in_m_no_stall");
    drive_pipe(1, 10, 0, 0, 2, 8); drive_d(0, 0, 3, 3, 0); drive_e(8, 0, 0);
    cycle("lw_wb_fwd_rs_e");

    // beq needing an ALU result in D
    idle(); drive_d(9, 0, 0, 3, 0); drive_pipe(1, 9, 0, 0, 0, 0);
    cycle("beq_alu_stall");
    drive_pipe(0, 0, 1, 9, 0, 0);
    cycle("beq_fwd_m_alu");

    // jal / jr link forwarding and priority
    idle(); drive_d(31, 0, 0, 3, 0); drive_pipe(3, 31, 0, 0, 0, 0);
    cycle("jr_fwd_pc8_e");
    drive_pipe(3, 31, 0, 0, 2, 31);
    cycle("e_beats_w");
    drive_pipe(0, 0, 3, 31, 0, 0);
    cycle("jr_fwd_pc8_m");
    drive_pipe(1, 4, 2, 31, 1, 31);
    cycle("m_dm_no_fwd");
    drive_d(0, 7, 3, 2, 0); drive_pipe(0, 0, 0, 0, 1, 7);
    cycle("rt_fwd_wb");

    // register 0 and M-stage store data
    idle(); drive_pipe(1, 0, 1, 0, 1, 0); drive_e(0, 0, 0); drive_d(0, 0, 0, 0, 0);
    cycle("reg0_never_fwd");
    drive_pipe(0, 0, 0, 0, 2, 5); drive_e(0, 0, 5);
    cycle("fwd_rt_m_wb");
    drive_pipe(0, 0, 3, 6, 1, 6); drive_e(6, 6, 0);
    cycle("e_fwd_m_over_w");
    drive_pipe(0, 0, 2, 6, 1, 6);
    cycle("e_fwd_m_dm_skips");

    // div then mflo
    idle(); drive_d(0, 0, 3, 3, 1); drive_md(1, 1);
    cycle("div_issue");
    drive_md(0, 0);
    repeat (10) cycle("div_busy");
    cycle("div_released");
    drive_md(1, 0);
    cycle("mult_issue");
    drive_md(0, 0);
    repeat (6) cycle("mult_busy");

    // reset mid-div, then reset together with md_start
    idle(); drive_md(1, 1);
    cycle("div2_issue");
    drive_md(0, 0);
    repeat (6) cycle("div2_count");
    reset = 1'b1;
    cycle("reset_mid_div");
    drive_md(1, 1);
    cycle("reset_vs_start");
    reset = 1'b0; drive_md(0, 0); drive_d(0, 0, 3, 3, 1);
    cycle("after_reset_idle");

    // randomized traffic over a small register set to provoke matches
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      drive_pipe($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      drive_e($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      drive_md($urandom_range(0, 9) == 0, $urandom_range(0, 1));
      cycle("random");
    end

    // stall counter saturation
    reset = 1'b1; idle();
    cycle("sat_reset");
    reset = 1'b0;
    drive_pipe(2, 8, 0, 0, 0, 0); drive_d(8, 0, 0, 3, 0);
    repeat (SAT + 8) cycle("sat_hold");
    idle();
    cycle("sat_released");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage pipeline.
- Consumes the per-stage control-pipe outputs (Res, A3 in E/M/W) and D-stage operand requirements.
- Produces the stall and bubble controls for the IF/ID and ID/EX pipe registers, plus forwarding-mux selects for D, E and M.
- Owns the sequential multiply/divide busy tracker and a stall-cycle performance counter.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu issues in E.
- DIV_CYC, 10, busy cycles after a div/divu issues in E.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- A1_D  in  5  rs index of the instruction in D.
- A2_D  in  5  rt index of the instruction in D.
- tuse_rs  in  2  cycles until rs is needed: 0 = D, 1 = E, 2 = M, 3 = unused.
- tuse_rt  in  2  same encoding, for rt.
- md_use_D  in  1  instruction in D is a mult/div/mfhi/mflo/mthi/mtlo.
- A1_E  in  5  rs index, E stage.
- A2_E  in  5  rt index, E stage.
- A2_M  in  5  rt index, M stage.
- Res_E, Res_M, Res_W  in  2 each  result source: 0 = none, 1 = ALU, 2 = DM, 3 = PC8 link.
- A3_E, A3_M, A3_W  in  5 each  destination register per stage.
- md_start  in  1  mult/div issuing in E this cycle.
- md_is_div  in  1  qualifies md_start (1 = div).
- stall  out  1  hold the PC and IF/ID.
- flush_E  out  1  clear ID/EX and ControlPipeE on the next edge.
- fwd_rs_D, fwd_rt_D  out  3 each  D compare/jr operand select: 0 = GRF, 1 = PC8_E, 2 = AO_M, 3 = PC8_M, 4 = WB data.
- fwd_rs_E, fwd_rt_E  out  2 each  ALU operand select: 0 = ID/EX value, 1 = M data (AO_M or PC8_M), 2 = WB data.
- fwd_rt_M  out  1  DM write data select: 0 = EX/MEM value, 1 = WB data.
- fwd_M_pc  out  1  M-stage forward value is PC8_M (Res_M == 3), else AO_M.
- md_busy  out  1  busy counter non-zero.
- stall_cnt  out  CNT_W  total stalled cycles.

Behaviour:
- Tnew per stage, derived from Res:
  - E: ALU = 1, DM = 2, PC8 = 0.
  - M: ALU = 0, DM = 1, PC8 = 0.
  - W: always 0.
  - Res = 0 never matches.
- Match rule: a stage matches operand X when A3 of that stage equals the operand index, A3 != 0, and Res != 0.
- Data stall: asserted for rs or rt when tuse != 3 and some matching stage (the youngest match only: E, then M, then W) has Tnew > tuse.
- MD stall: asserted when md_use_D && (md_busy || md_start).
- stall = data stall | MD stall; flush_E = stall. Both are combinational from current inputs and registered state, with no extra latency.
- D forwarding:
  - Priority E > M > W, using the youngest matching stage.
  - E forwards only when Res_E == 3 (sel 1).
  - M gives 2 (ALU) or 3 (PC8); Res_M == 2 gives no M forward (the stall covers it).
  - W gives 4; otherwise 0.
- E forwarding on A1_E/A2_E: M match with Res_M ∈ {1, 3} gives 1; else W match gives 2; else 0.
- M forwarding on A2_M: W match gives 1.
- Register 0 never forwards, even if A3 == 0 with Res != 0.
- Busy counter:
  - md_start loads MULT_CYC or DIV_CYC on the next edge.
  - Otherwise decrements by 1 while non-zero; md_busy = (counter != 0).
  - md_start while busy reloads the counter; a new load wins over the decrement.
- stall_cnt:
  - Increments by 1 on each edge where stall = 1.
  - Saturates at all-ones and does not wrap.
- Reset:
  - Counter = 0, stall_cnt = 0, md_busy = 0.
  - Reset has priority over md_start on the same edge.
  - Combinational outputs follow their inputs. The control pipes themselves reset to 0, which yields stall = 0, flush_E = 0 and all selects 0 during and after reset.

Test Plan:
- lw $t0 in E (Res_E = 2, A3_E = 8) with addu in D using rs = 8, tuse_rs = 1 -> stall = 1, flush_E = 1 for 1 cycle. The next cycle has lw in M: stall = 0 and fwd_rs_E = 0, then W data via fwd_rs_E = 2 one stage later. stall_cnt = 1.
- beq in D (tuse_rs = 0, A1_D = 9) with addu in E (Res_E = 1, A3_E = 9) -> stall 1 cycle. Next cycle Res_M = 1, A3_M = 9 -> fwd_rs_D = 2, stall = 0.
- jal in E (Res_E = 3, A3_E = 31) with jr $ra in D -> fwd_rs_D = 1, stall = 0. Same destination in both E and W -> E wins.
- A3_M = 0, Res_M = 1, A1_E = 0 -> fwd_rs_E = 0. A3_W = 5 with A2_M = 5, Res_W = 2 -> fwd_rt_M = 1.
- md_start with md_is_div = 1, then mflo in D -> md_busy high for 10 cycles, stall = 1 on each of them (plus the issue cycle if mflo is already in D). stall_cnt advances accordingly. Releases when the counter reaches 0.
- Reset asserted mid-div with counter = 4 -> md_busy = 0 and stall_cnt = 0 after the edge. Reset and md_start on the same edge -> counter stays 0.
